// File: rtl/mult_product_accumulator.sv
// ---------------------------------------------------------------------------
// mult_product_accumulator
//   Sums 8-bit unsigned products from the 4x4 array multiplier into an
//   ACC_W-bit accumulator. A sum closes on prod_last or after MAX_TERMS
//   products. The completed sum is then held on a valid/ready output
//   handshake until the consumer takes it.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   clear       synchronous abort of the partial or held sum
//   prod_valid  / prod_ready / prod_data[7:0] / prod_last : product input
//   acc_valid   / acc_ready  : completed-sum handshake
//   acc_data[ACC_W-1:0]      completed sum
//   acc_count[CNT_W-1:0]     number of products in the sum
//   acc_ovf                  sum overflowed ACC_W at least once
// ---------------------------------------------------------------------------
module mult_product_accumulator #(
  parameter int ACC_W     = 16,
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = 5,
  parameter int SATURATE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic [7:0]       prod_data,
  input  logic             prod_last,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc_data,
  output logic [CNT_W-1:0] acc_count,
  output logic             acc_ovf
);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_TERMS - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_prod_ready;
  logic [ACC_W-1:0] r_acc_data;
  logic [CNT_W-1:0] r_acc_count;
  logic             r_acc_ovf;

  logic             w_prod_hs;
  logic             w_res_hs;
  logic             w_close;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic [ACC_W-1:0] w_acc_next;

  // Handshakes. prod_ready is only ever high in ACCUM, so a product
  // handshake implies ACCUM.
  assign w_prod_hs = prod_valid & r_prod_ready;
  assign w_res_hs  = (r_state == ST_HOLD) & acc_ready;

  // A single close event covers prod_last and the MAX_TERMS rollover, so a
  // coincident pair still closes the sum once.
  assign w_close = w_prod_hs & (prod_last | (r_acc_count == LAST_IDX));

  // One extra bit captures the carry out of the accumulator MSB.
  assign w_sum      = {1'b0, r_acc_data} + {{(ACC_W - 7){1'b0}}, prod_data};
  assign w_carry    = w_sum[ACC_W];
  assign w_acc_next = ((SATURATE != 0) && w_carry) ? '1 : w_sum[ACC_W-1:0];

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_ACCUM;
    else     r_state <= w_next_state;
  end

  // Next-state logic; clear overrides any handshake in the same cycle.
  always_comb begin
    // NOTE: a default assignment before any branch keeps this block free of
    // inferred latches.
    w_next_state = r_state;
    if (clear) begin
      w_next_state = ST_ACCUM;
    end else begin
      unique case (r_state)
        ST_ACCUM: if (w_close)  w_next_state = ST_HOLD;
        ST_HOLD:  if (w_res_hs) w_next_state = ST_ACCUM;
        default:                w_next_state = ST_ACCUM;
      endcase
    end
  end

  // Output logic
  always_comb begin
    acc_valid  = (r_state == ST_HOLD);
    prod_ready = r_prod_ready;
    acc_data   = r_acc_data;
    acc_count  = r_acc_count;
    acc_ovf    = r_acc_ovf;
  end

  // prod_ready is registered: high only when the block is in ACCUM now and
  // stays there. Leaving HOLD therefore costs one dead cycle before the next
  // product can be taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prod_ready <= 1'b0;
    else     r_prod_ready <= (r_state == ST_ACCUM) && (w_next_state == ST_ACCUM);
  end

  // Accumulator datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_data  <= '0;
      r_acc_count <= '0;
      r_acc_ovf   <= 1'b0;
    end else if (clear || w_res_hs) begin
      r_acc_data  <= '0;
      r_acc_count <= '0;
      r_acc_ovf   <= 1'b0;
    end else if (w_prod_hs) begin
      r_acc_data  <= w_acc_next;
      r_acc_count <= r_acc_count + 1'b1;
      r_acc_ovf   <= r_acc_ovf | w_carry;
    end
  end

endmodule

// File: tb/tb_mult_product_accumulator.sv
module tb_mult_product_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       prod_valid = 1'b0;
  logic [7:0] prod_data = 8'd0;
  logic       prod_last = 1'b0;
  logic       acc_ready = 1'b0;

  // Default configuration
  logic        rdy0, vld0, ovf0;
  logic [15:0] data0;
  logic [4:0]  cnt0;
  // ACC_W=10, wrapping
  logic        rdy1, vld1, ovf1;
  logic [9:0]  data1;
  logic [4:0]  cnt1;
  // ACC_W=10, saturating
  logic        rdy2, vld2, ovf2;
  logic [9:0]  data2;
  logic [4:0]  cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_product_accumulator dut0 (
    .clk(clk), .rst(rst), .clear(clear),
    .prod_valid(prod_valid), .prod_ready(rdy0), .prod_data(prod_data), .prod_last(prod_last),
    .acc_valid(vld0), .acc_ready(acc_ready), .acc_data(data0), .acc_count(cnt0), .acc_ovf(ovf0)
  );

  mult_product_accumulator #(.ACC_W(10), .SATURATE(0)) dut1 (
    .clk(clk), .rst(rst), .clear(clear),
    .prod_valid(prod_valid), .prod_ready(rdy1), .prod_data(prod_data), .prod_last(prod_last),
    .acc_valid(vld1), .acc_ready(acc_ready), .acc_data(data1), .acc_count(cnt1), .acc_ovf(ovf1)
  );

  mult_product_accumulator #(.ACC_W(10), .SATURATE(1)) dut2 (
    .clk(clk), .rst(rst), .clear(clear),
    .prod_valid(prod_valid), .prod_ready(rdy2), .prod_data(prod_data), .prod_last(prod_last),
    .acc_valid(vld2), .acc_ready(acc_ready), .acc_data(data2), .acc_count(cnt2), .acc_ovf(ovf2)
  );

  // Offer one product and return #1 after the edge on which it was taken.
  task automatic push(input logic [7:0] d, input logic last);
    int waited = 0;
    @(negedge clk);
    prod_valid = 1'b1; prod_data = d; prod_last = last;
    while (!rdy0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (rdy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL push_timeout: prod_ready got %b expected 1 (data %0d)", rdy0, d);
    end
    @(posedge clk); #1;
    prod_valid = 1'b0; prod_data = 8'd0; prod_last = 1'b0;
  endtask

  // Take the held sum; returns #1 after the consuming edge.
  task automatic consume();
    @(negedge clk);
    acc_ready = 1'b1;
    @(posedge clk); #1;
    acc_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (vld0 !== 1'b0)  begin n_fail++; $display("FAIL rst_valid: got %b expected 0", vld0); end
    n_checks++; if (rdy0 !== 1'b0)  begin n_fail++; $display("FAIL rst_ready: got %b expected 0", rdy0); end
    n_checks++; if (data0 !== 16'd0) begin n_fail++; $display("FAIL rst_data: got %0d expected 0", data0); end
    n_checks++; if (cnt0 !== 5'd0)  begin n_fail++; $display("FAIL rst_count: got %0d expected 0", cnt0); end
    n_checks++; if (ovf0 !== 1'b0)  begin n_fail++; $display("FAIL rst_ovf: got %b expected 0", ovf0); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (rdy0 !== 1'b1)  begin n_fail++; $display("FAIL rst_release_ready: got %b expected 1", rdy0); end
  endtask

  task automatic test_basic_sum();
    acc_ready = 1'b1;
    push(8'd15, 1'b0);
    push(8'd30, 1'b0);
    n_checks++; if (vld0 !== 1'b0)   begin n_fail++; $display("FAIL basic_early_valid: got %b expected 0", vld0); end
    n_checks++; if (data0 !== 16'd45) begin n_fail++; $display("FAIL basic_partial: got %0d expected 45", data0); end
    push(8'd45, 1'b1);
    n_checks++; if (vld0 !== 1'b1)   begin n_fail++; $display("FAIL basic_valid: got %b expected 1", vld0); end
    n_checks++; if (data0 !== 16'd90) begin n_fail++; $display("FAIL basic_data: got %0d expected 90", data0); end
    n_checks++; if (cnt0 !== 5'd3)   begin n_fail++; $display("FAIL basic_count: got %0d expected 3", cnt0); end
    n_checks++; if (ovf0 !== 1'b0)   begin n_fail++; $display("FAIL basic_ovf: got %b expected 0", ovf0); end
    n_checks++; if (rdy0 !== 1'b0)   begin n_fail++; $display("FAIL basic_hold_ready: got %b expected 0", rdy0); end
    @(posedge clk); #1;
    n_checks++; if (vld0 !== 1'b0)   begin n_fail++; $display("FAIL basic_consumed: got %b expected 0", vld0); end
    n_checks++; if (data0 !== 16'd0) begin n_fail++; $display("FAIL basic_cleared: got %0d expected 0", data0); end
    n_checks++; if (rdy0 !== 1'b0)   begin n_fail++; $display("FAIL basic_dead_cycle: got %b expected 0", rdy0); end
    @(posedge clk); #1;
    n_checks++; if (rdy0 !== 1'b1)   begin n_fail++; $display("FAIL basic_ready_back: got %b expected 1", rdy0); end
    acc_ready = 1'b0;
  endtask

  task automatic test_max_terms();
    for (int i = 1; i <= 16; i++) begin
      push(8'd225, 1'b0);
      if (i == 15) begin
        n_checks++; if (vld0 !== 1'b0) begin n_fail++; $display("FAIL max_early_close: got %b expected 0", vld0); end
      end
    end
    n_checks++; if (vld0 !== 1'b1)     begin n_fail++; $display("FAIL max_valid: got %b expected 1", vld0); end
    n_checks++; if (data0 !== 16'd3600) begin n_fail++; $display("FAIL max_data: got %0d expected 3600", data0); end
    n_checks++; if (cnt0 !== 5'd16)    begin n_fail++; $display("FAIL max_count: got %0d expected 16", cnt0); end
    n_checks++; if (rdy0 !== 1'b0)     begin n_fail++; $display("FAIL max_hold_ready: got %b expected 0", rdy0); end
    @(posedge clk); #1;
    n_checks++; if (data0 !== 16'd3600) begin n_fail++; $display("FAIL max_stable: got %0d expected 3600", data0); end
    consume();
    n_checks++; if (vld0 !== 1'b0)     begin n_fail++; $display("FAIL max_consumed: got %b expected 0", vld0); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) push(8'd255, 1'b0);
    push(8'd255, 1'b1);
    n_checks++; if (data1 !== 10'd251)  begin n_fail++; $display("FAIL ovf_wrap_data: got %0d expected 251", data1); end
    n_checks++; if (ovf1 !== 1'b1)      begin n_fail++; $display("FAIL ovf_wrap_flag: got %b expected 1", ovf1); end
    n_checks++; if (cnt1 !== 5'd5)      begin n_fail++; $display("FAIL ovf_wrap_count: got %0d expected 5", cnt1); end
    n_checks++; if (data2 !== 10'd1023) begin n_fail++; $display("FAIL ovf_sat_data: got %0d expected 1023", data2); end
    n_checks++; if (ovf2 !== 1'b1)      begin n_fail++; $display("FAIL ovf_sat_flag: got %b expected 1", ovf2); end
    n_checks++; if (data0 !== 16'd1275) begin n_fail++; $display("FAIL ovf_wide_data: got %0d expected 1275", data0); end
    n_checks++; if (ovf0 !== 1'b0)      begin n_fail++; $display("FAIL ovf_wide_flag: got %b expected 0", ovf0); end
    consume();
    n_checks++; if (ovf1 !== 1'b0)      begin n_fail++; $display("FAIL ovf_flag_cleared: got %b expected 0", ovf1); end
  endtask

  task automatic test_backpressure();
    push(8'd7, 1'b0);
    push(8'd8, 1'b1);
    @(negedge clk);
    prod_valid = 1'b1; prod_data = 8'd99;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++; if (data0 !== 16'd15) begin n_fail++; $display("FAIL bp_data[%0d]: got %0d expected 15", i, data0); end
      n_checks++; if (vld0 !== 1'b1)    begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, vld0); end
      n_checks++; if (rdy0 !== 1'b0)    begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, rdy0); end
      n_checks++; if (cnt0 !== 5'd2)    begin n_fail++; $display("FAIL bp_count[%0d]: got %0d expected 2", i, cnt0); end
    end
    @(negedge clk); acc_ready = 1'b1;
    @(posedge clk); #1;
    acc_ready = 1'b0; prod_valid = 1'b0; prod_data = 8'd0;
    n_checks++; if (vld0 !== 1'b0)   begin n_fail++; $display("FAIL bp_consumed: got %b expected 0", vld0); end
    n_checks++; if (data0 !== 16'd0) begin n_fail++; $display("FAIL bp_zeroed: got %0d expected 0", data0); end
    push(8'd5, 1'b1);
    n_checks++; if (data0 !== 16'd5) begin n_fail++; $display("FAIL bp_next_data: got %0d expected 5", data0); end
    n_checks++; if (cnt0 !== 5'd1)   begin n_fail++; $display("FAIL bp_next_count: got %0d expected 1", cnt0); end
    consume();
  endtask

  task automatic test_clear();
    push(8'd100, 1'b0);
    push(8'd100, 1'b0);
    @(negedge clk);
    prod_valid = 1'b1; prod_data = 8'd50; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; prod_valid = 1'b0; prod_data = 8'd0;
    n_checks++; if (data0 !== 16'd0) begin n_fail++; $display("FAIL clr_data: got %0d expected 0", data0); end
    n_checks++; if (cnt0 !== 5'd0)   begin n_fail++; $display("FAIL clr_count: got %0d expected 0", cnt0); end
    n_checks++; if (vld0 !== 1'b0)   begin n_fail++; $display("FAIL clr_valid: got %b expected 0", vld0); end
    push(8'd9, 1'b1);
    n_checks++; if (data0 !== 16'd9) begin n_fail++; $display("FAIL clr_next_data: got %0d expected 9", data0); end
    n_checks++; if (cnt0 !== 5'd1)   begin n_fail++; $display("FAIL clr_next_count: got %0d expected 1", cnt0); end
    // clear beats a result handshake in HOLD
    @(negedge clk);
    clear = 1'b1; acc_ready = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; acc_ready = 1'b0;
    n_checks++; if (vld0 !== 1'b0)   begin n_fail++; $display("FAIL clr_hold_valid: got %b expected 0", vld0); end
    n_checks++; if (data0 !== 16'd0) begin n_fail++; $display("FAIL clr_hold_data: got %0d expected 0", data0); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) push(8'd255, 1'b0);
    push(8'd255, 1'b1);
    n_checks++; if (vld0 !== 1'b1) begin n_fail++; $display("FAIL arst_pre_valid: got %b expected 1", vld0); end
    n_checks++; if (ovf1 !== 1'b1) begin n_fail++; $display("FAIL arst_pre_ovf: got %b expected 1", ovf1); end
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    n_checks++; if (vld0 !== 1'b0)    begin n_fail++; $display("FAIL arst_valid: got %b expected 0", vld0); end
    n_checks++; if (data0 !== 16'd0)  begin n_fail++; $display("FAIL arst_data: got %0d expected 0", data0); end
    n_checks++; if (cnt0 !== 5'd0)    begin n_fail++; $display("FAIL arst_count: got %0d expected 0", cnt0); end
    n_checks++; if (ovf1 !== 1'b0)    begin n_fail++; $display("FAIL arst_ovf: got %b expected 0", ovf1); end
    n_checks++; if (data1 !== 10'd0)  begin n_fail++; $display("FAIL arst_data1: got %0d expected 0", data1); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (rdy0 !== 1'b1)    begin n_fail++; $display("FAIL arst_release_ready: got %b expected 1", rdy0); end
    n_checks++; if (vld0 !== 1'b0)    begin n_fail++; $display("FAIL arst_release_valid: got %b expected 0", vld0); end
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_max_terms();
    test_overflow();
    test_backpressure();
    test_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
